// File: rtl/uartlite_pkg.sv
// Shared constants and types for the UART Lite TX feeder: register map, status bit, FSM states, AXI response codes.
package uartlite_pkg;

  localparam logic [3:0] CTRL_ADDR_DEF = 4'hC;
  localparam logic [3:0] STAT_ADDR_DEF = 4'h8;
  localparam logic [3:0] TXF_ADDR_DEF  = 4'h4;
  localparam logic [7:0] CTRL_INIT_DEF = 8'h13;
  localparam int         POLL_GAP_DEF  = 4;

  localparam int TXF_FULL = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    CFG_WR, CFG_B, IDLE, ST_AR, ST_R, ST_GAP, TX_WR, TX_B
  } state_t;

endpackage

// File: rtl/axil_wr_chan.sv
// AXI4-Lite AW/W issue: both valids rise on start, each drops after its own handshake; done when both complete.
// Registered valids, zero added latency; holds addr/data stable until the slave accepts.
module axil_wr_chan
  import uartlite_pkg::*;
(
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  input  logic [3:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic        done
);

  logic active;

  // Done in the cycle the last outstanding channel handshakes.
  assign done = active && (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      active        <= 1'b0;
    end else if (start) begin
      m_axi_awaddr  <= addr;
      m_axi_awvalid <= 1'b1;
      m_axi_wdata   <= data;
      m_axi_wvalid  <= 1'b1;
      active        <= 1'b1;
    end else begin
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
      if (done)                           active        <= 1'b0;
    end
  end

endmodule

// File: rtl/uartlite_tx_feeder.sv
// AXI4-Lite master feeding bytes into the UART Lite TX FIFO; configures the core once after reset.
// Best case 2 cycles from accept to AW/W; s_ready low until the byte's write response; UTX_ERR_CNT_EN adds err_count.
module uartlite_tx_feeder
  import uartlite_pkg::*;
#(
  parameter logic [3:0] CTRL_ADDR = CTRL_ADDR_DEF,
  parameter logic [3:0] STAT_ADDR = STAT_ADDR_DEF,
  parameter logic [3:0] TXF_ADDR  = TXF_ADDR_DEF,
  parameter logic [7:0] CTRL_INIT = CTRL_INIT_DEF,
  parameter int         POLL_GAP  = POLL_GAP_DEF
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [3:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        busy,
`ifdef UTX_ERR_CNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        resp_err
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t        state;
  logic          cfg_pend;
  logic [7:0]    byte_q;
  logic [GW-1:0] gap_cnt;
  logic          wr_start;
  logic          wr_done;
  logic          rd_ok;
  logic          b_err;
  logic          unused_rdata;

  assign unused_rdata = ^{m_axi_rdata[31:TXF_FULL+1], m_axi_rdata[TXF_FULL-1:0]};
  assign m_axi_wstrb  = 4'h1;
  assign rd_ok        = (m_axi_rresp == RESP_OKAY) && !m_axi_rdata[TXF_FULL];
  assign b_err        = m_axi_bvalid && (m_axi_bresp != RESP_OKAY) && (state == CFG_B || state == TX_B);

  // cfg_pend marks the one config write after reset; it also steers the write mux.
  assign wr_start = (state == CFG_WR && cfg_pend) ||
                    (state == ST_R && m_axi_rvalid && m_axi_rready && rd_ok);

  axil_wr_chan u_wr (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .start         (wr_start),
    .addr          (cfg_pend ? CTRL_ADDR : TXF_ADDR),
    .data          ({24'h0, cfg_pend ? CTRL_INIT : byte_q}),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .done          (wr_done)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= CFG_WR;
      cfg_pend      <= 1'b1;
      byte_q        <= '0;
      gap_cnt       <= '0;
      s_ready       <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b1;
      resp_err      <= 1'b0;
    end else begin
      resp_err <= 1'b0;
      case (state)
        CFG_WR, TX_WR: begin
          cfg_pend <= 1'b0;
          if (wr_done) begin
            m_axi_bready <= 1'b1;
            state        <= (state == CFG_WR) ? CFG_B : TX_B;
          end
        end
        // Errored responses are reported and the byte is dropped, never retried.
        CFG_B, TX_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp_err     <= b_err;
            s_ready      <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        IDLE: begin
          if (s_valid && s_ready) begin
            byte_q        <= s_data;
            s_ready       <= 1'b0;
            busy          <= 1'b1;
            m_axi_araddr  <= STAT_ADDR;
            m_axi_arvalid <= 1'b1;
            state         <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            gap_cnt      <= '0;
            state        <= rd_ok ? TX_WR : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            m_axi_arvalid <= 1'b1;
            state         <= ST_AR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= CFG_WR;
      endcase
    end
  end

`ifdef UTX_ERR_CNT_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                   err_count <= '0;
    else if (b_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uartlite_tx_feeder.sv
// Directed bench for uartlite_tx_feeder: AXI4-Lite slave model, table of byte transactions, reset corner cases.
module tb_uartlite_tx_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [3:0]  m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;
  logic        busy, resp_err;
`ifdef UTX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  uartlite_tx_feeder dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .busy(busy),
`ifdef UTX_ERR_CNT_EN
    .err_count(err_count),
`endif
    .resp_err(resp_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Slave model controls and observations
  int          aw_dly = 0, w_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          b_hold = 1'b0;
  logic [33:0] stat_q[$];
  logic [3:0]  wa_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  ws_log[$];
  int          aw_cnt, w_cnt, b_cnt = 0, ar_cnt = 0, err_pulses = 0, viol = 0, aw_first = -1;
  bit          aw_pend, w_pend, b_fire, r_fire, ar_pend;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_err;
  logic [3:0]  p_awa, p_ara;
  logic [31:0] p_wd;

  int n_err = 0, n_checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Slave: acts on falling edges, so its outputs are stable at each rising edge.
  initial begin
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        m_axi_bresp = 2'b00; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        aw_cnt = 0; w_cnt = 0;
        {aw_pend, w_pend, b_fire, r_fire, ar_pend} = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_err} = '0;
      end else begin
        if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awa)) viol++;
        if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wd)) viol++;
        if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_ara)) viol++;
        if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid)) viol++;
        if (resp_err) begin
          err_pulses++;
          if (p_err) viol++;
        end
        if (m_axi_awvalid && aw_first < 0) aw_first = cyc;

        if (b_fire) begin
          m_axi_bvalid = 1'b0; b_fire = 1'b0;
        end else if (m_axi_bvalid) begin
          if (m_axi_bready) b_fire = 1'b1;
        end else if (aw_pend && w_pend && !b_hold) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg;
          aw_pend = 1'b0; w_pend = 1'b0; b_cnt++;
          b_fire = m_axi_bready;
        end

        if (m_axi_awready) m_axi_awready = 1'b0;
        else if (m_axi_awvalid) begin
          if (aw_cnt >= aw_dly) begin
            m_axi_awready = 1'b1; aw_pend = 1'b1; aw_cnt = 0;
            wa_log.push_back(m_axi_awaddr);
          end else aw_cnt++;
        end

        if (m_axi_wready) m_axi_wready = 1'b0;
        else if (m_axi_wvalid) begin
          if (w_cnt >= w_dly) begin
            m_axi_wready = 1'b1; w_pend = 1'b1; w_cnt = 0;
            wd_log.push_back(m_axi_wdata);
            ws_log.push_back(m_axi_wstrb);
          end else w_cnt++;
        end

        if (r_fire) begin
          m_axi_rvalid = 1'b0; r_fire = 1'b0;
        end else if (m_axi_rvalid) begin
          if (m_axi_rready) r_fire = 1'b1;
        end else if (ar_pend) begin
          m_axi_rvalid = 1'b1;
          {m_axi_rresp, m_axi_rdata} = (stat_q.size() > 0) ? stat_q.pop_front() : 34'h0;
          ar_pend = 1'b0;
          r_fire = m_axi_rready;
        end

        if (m_axi_arready) m_axi_arready = 1'b0;
        else if (m_axi_arvalid) begin
          m_axi_arready = 1'b1; ar_pend = 1'b1; ar_cnt++;
          if (m_axi_araddr != 4'h8) viol++;
        end

        p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awa = m_axi_awaddr;
        p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wd  = m_axi_wdata;
        p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_ara = m_axi_araddr;
        p_err = resp_err;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, input int lim);
    int n = 0;
    while (!s_ready && n < lim) begin
      step();
      n++;
    end
    if (!s_ready) begin
      n_checks++; n_err++;
      $display("FAIL timeout_%s: s_ready still 0 after %0d cycles, required 1", nm, lim);
    end
  endtask

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); ws_log.delete(); stat_q.delete();
    ar_cnt = 0; b_cnt = 0; err_pulses = 0; aw_first = -1;
  endtask

  typedef struct {
    logic [7:0]  data;
    int          n_full;
    logic [1:0]  full_rresp;
    logic [31:0] full_val;
    logic [31:0] ok_val;
    logic [1:0]  bresp;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp_wdata;
    int          exp_ar;
    int          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];
  int   exp_err_total = 0;

  initial begin
    s_data = 8'h00; s_valid = 1'b0;

    // Each extra status poll costs ST_AR + ST_R + 4 gap cycles = 6 cycles.
    vecs[0] = '{8'hAA, 0, 2'b00, 32'h0,         32'h0000_0000, 2'b00, 0, 0, 32'h0000_00AA, 1, 0, 2};
    vecs[1] = '{8'h55, 2, 2'b00, 32'h0000_0008, 32'h0000_00F7, 2'b00, 0, 0, 32'h0000_0055, 3, 0, 14};
    vecs[2] = '{8'h3C, 0, 2'b00, 32'h0,         32'h0000_0004, 2'b00, 3, 0, 32'h0000_003C, 1, 0, 2};
    vecs[3] = '{8'hC3, 0, 2'b00, 32'h0,         32'h0000_0000, 2'b10, 0, 0, 32'h0000_00C3, 1, 1, 2};
    vecs[4] = '{8'h01, 1, 2'b10, 32'h0,         32'h0000_0000, 2'b00, 0, 2, 32'h0000_0001, 2, 0, 8};
    vecs[5] = '{8'hFF, 1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 1, 1, 32'h0000_00FF, 2, 1, 8};
    vecs[6] = '{8'h00, 0, 2'b00, 32'h0,         32'h0000_0000, 2'b00, 2, 2, 32'h0000_0000, 1, 0, 2};

    repeat (3) step();
    check("rst_awvalid", 32'(m_axi_awvalid), 0);
    check("rst_wvalid",  32'(m_axi_wvalid), 0);
    check("rst_arvalid", 32'(m_axi_arvalid), 0);
    check("rst_bready",  32'(m_axi_bready), 0);
    check("rst_rready",  32'(m_axi_rready), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    check("rst_busy",    32'(busy), 1);
    check("rst_awaddr",  32'(m_axi_awaddr), 0);
    check("rst_wdata",   m_axi_wdata, 0);
    check("rst_araddr",  32'(m_axi_araddr), 0);
`ifdef UTX_ERR_CNT_EN
    check("rst_err_count", 32'(err_count), 0);
`endif

    // Config write after reset release
    @(negedge clk); rst_n = 1'b1;
    begin
      int n = 0;
      while (wa_log.size() == 0 && n < 50) begin
        step();
        n++;
      end
    end
    check("cfg_aw_seen",  32'(wa_log.size()), 1);
    check("cfg_s_ready_low", 32'(s_ready), 0);
    wait_ready("cfg", 100);
    check("cfg_awaddr", 32'(wa_log[0]), 32'hC);
    check("cfg_wdata",  wd_log[0], 32'h0000_0013);
    check("cfg_wstrb",  32'(ws_log[0]), 32'h1);
    check("cfg_b_cnt",  32'(b_cnt), 1);
    check("cfg_busy",   32'(busy), 0);
    check("cfg_ar_cnt", 32'(ar_cnt), 0);

    foreach (vecs[i]) begin
      aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; bresp_cfg = vecs[i].bresp;
      clear_logs();
      for (int k = 0; k < vecs[i].n_full; k++) stat_q.push_back({vecs[i].full_rresp, vecs[i].full_val});
      stat_q.push_back({2'b00, vecs[i].ok_val});
      exp_err_total += vecs[i].exp_err;
      begin
        int hs;
        s_data = vecs[i].data; s_valid = 1'b1;
        step();
        s_valid = 1'b0; hs = cyc;
        check($sformatf("v%0d_s_ready_drop", i), 32'(s_ready), 0);
        check($sformatf("v%0d_busy", i), 32'(busy), 1);
        wait_ready($sformatf("v%0d", i), 300);
        check($sformatf("v%0d_latency", i), 32'(aw_first - hs), 32'(vecs[i].exp_lat));
      end
      check($sformatf("v%0d_writes", i), 32'(wd_log.size()), 1);
      check($sformatf("v%0d_awaddr", i), 32'(wa_log[0]), 32'h4);
      check($sformatf("v%0d_wdata", i), wd_log[0], vecs[i].exp_wdata);
      check($sformatf("v%0d_wstrb", i), 32'(ws_log[0]), 32'h1);
      check($sformatf("v%0d_ar_cnt", i), 32'(ar_cnt), 32'(vecs[i].exp_ar));
      check($sformatf("v%0d_b_cnt", i), 32'(b_cnt), 1);
      check($sformatf("v%0d_err_pulses", i), 32'(err_pulses), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
    end
`ifdef UTX_ERR_CNT_EN
    check("err_count", 32'(err_count), 32'(exp_err_total));
`endif

    // Reset while waiting for the TX write response
    aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00;
    clear_logs();
    b_hold = 1'b1;
    stat_q.push_back(34'h0);
    s_data = 8'h77; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    begin
      int n = 0;
      while (!m_axi_bready && n < 100) begin
        step();
        n++;
      end
      if (!m_axi_bready) begin
        n_checks++; n_err++;
        $display("FAIL timeout_txb: bready still 0 after %0d cycles, required 1", n);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", 32'(m_axi_awvalid), 0);
    check("mid_rst_wvalid",  32'(m_axi_wvalid), 0);
    check("mid_rst_arvalid", 32'(m_axi_arvalid), 0);
    check("mid_rst_bready",  32'(m_axi_bready), 0);
    check("mid_rst_rready",  32'(m_axi_rready), 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_busy",    32'(busy), 1);
    check("mid_rst_wdata",   m_axi_wdata, 0);
`ifdef UTX_ERR_CNT_EN
    check("mid_rst_err_count", 32'(err_count), 0);
`endif
    b_hold = 1'b0;
    repeat (2) step();
    clear_logs();
    @(negedge clk); rst_n = 1'b1;
    wait_ready("re_cfg", 100);
    check("re_cfg_writes", 32'(wd_log.size()), 1);
    check("re_cfg_awaddr", 32'(wa_log[0]), 32'hC);
    check("re_cfg_wdata",  wd_log[0], 32'h0000_0013);
    repeat (5) step();
    check("re_cfg_no_stale_tx", 32'(wd_log.size()), 1);
    check("protocol_violations", 32'(viol), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
